// File: rtl/mem_arbiter.sv
// Merges the CPU instruction-fetch and data ports onto one single-ported memory bus,
// with byte-lane alignment, stale-fetch abort and a watchdog on unacknowledged accesses.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        nrst,
    // instruction fetch port
    input  logic        imem_ren,
    input  logic [31:0] imem_addr,
    output logic        ihit,
    output logic [31:0] imem_load,
    // data port
    input  logic        dmem_ren,
    input  logic        dmem_wen,
    input  logic [31:0] dmem_addr,
    input  logic [2:0]  dmem_width,
    input  logic [31:0] dmem_store,
    output logic        dhit,
    output logic [31:0] dmem_load,
    output logic        access_fault,
    // memory bus
    output logic [31:0] ram_addr,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [3:0]  ram_be,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_load,
    input  logic        ram_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    state_t            w_next;

    logic [31:0]       r_addr;
    logic [2:0]        r_width;
    logic [31:0]       r_store;
    logic              r_wr;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_imem_load;
    logic [31:0]       r_dmem_load;

    logic              w_timeout;
    logic              w_done;
    logic              w_abort;
    logic              w_ihit;
    logic              w_dhit;
    logic [4:0]        w_shift;
    logic [3:0]        w_lane_be;
    logic [31:0]       w_lane_store;
    logic [31:0]       w_lane_load;
    logic [31:0]       w_iload;
    logic [31:0]       w_dload;

    // Completion: ram_ready wins over a same-cycle timeout, so a late acknowledge is never faulted.
    assign w_timeout = (r_cnt == LAST_CNT) && !ram_ready;
    assign w_done    = ram_ready || w_timeout;
    assign w_abort   = (r_state == IACC) && !ram_ready &&
                       (!imem_ren || (imem_addr != r_addr));
    assign w_ihit    = (r_state == IACC) && w_done && !w_abort;
    assign w_dhit    = (r_state == DACC) && w_done;
    assign w_iload   = ram_ready ? ram_load : 32'h0;
    assign w_dload   = ram_ready ? w_lane_load : 32'h0;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (dmem_ren || dmem_wen) begin
                    w_next = DACC;
                end else if (imem_ren) begin
                    w_next = IACC;
                end
            end
            DACC: begin
                if (w_done) begin
                    w_next = IDLE;
                end
            end
            IACC: begin
                if (w_done || w_abort) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request registers, watchdog counter and held load data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_addr      <= 32'h0;
            r_width     <= 3'b000;
            r_store     <= 32'h0;
            r_wr        <= 1'b0;
            r_cnt       <= '0;
            r_imem_load <= 32'h0;
            r_dmem_load <= 32'h0;
        end else begin
            if (r_state == IDLE) begin
                r_cnt <= '0;
                if (dmem_ren || dmem_wen) begin
                    r_addr  <= dmem_addr;
                    r_width <= dmem_width;
                    r_store <= dmem_store;
                    r_wr    <= dmem_wen;
                end else if (imem_ren) begin
                    r_addr  <= imem_addr;
                    r_width <= 3'b010;
                    r_store <= 32'h0;
                    r_wr    <= 1'b0;
                end
            end else if (!ram_ready) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_ihit) begin
                r_imem_load <= w_iload;
            end
            if (w_dhit && !r_wr) begin
                r_dmem_load <= w_dload;
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte-lane alignment of the latched data request
    // ------------------------------------------------------------------
    always_comb begin
        w_shift      = {r_addr[1:0], 3'b000};
        w_lane_be    = 4'b1111;
        w_lane_store = r_store;
        w_lane_load  = ram_load;
        // Width bit 2 is the datapath's sign flag and has no effect on lanes.
        casez (r_width)
            3'b?00: begin
                w_lane_be    = 4'b0001 << r_addr[1:0];
                w_lane_store = {24'h0, r_store[7:0]} << w_shift;
                w_lane_load  = (ram_load >> w_shift) & 32'h0000_00FF;
            end
            3'b?01: begin
                w_lane_be    = 4'b0011 << r_addr[1:0];
                w_lane_store = {16'h0, r_store[15:0]} << w_shift;
                w_lane_load  = (ram_load >> w_shift) & 32'h0000_FFFF;
            end
            default: begin
                w_lane_be    = 4'b1111;
                w_lane_store = r_store;
                w_lane_load  = ram_load;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ram_addr     = 32'h0;
        ram_ren      = 1'b0;
        ram_wen      = 1'b0;
        ram_be       = 4'b0000;
        ram_store    = 32'h0;
        ihit         = w_ihit;
        dhit         = w_dhit;
        access_fault = (w_ihit || w_dhit) && !ram_ready;
        imem_load    = w_ihit ? w_iload : r_imem_load;
        dmem_load    = (w_dhit && !r_wr) ? w_dload : r_dmem_load;
        unique case (r_state)
            DACC: begin
                ram_addr  = {r_addr[31:2], 2'b00};
                ram_ren   = !r_wr;
                ram_wen   = r_wr;
                ram_be    = w_lane_be;
                ram_store = r_wr ? w_lane_store : 32'h0;
            end
            IACC: begin
                ram_addr  = {r_addr[31:2], 2'b00};
                ram_ren   = 1'b1;
                ram_be    = 4'b1111;
            end
            default: begin
                ram_addr  = 32'h0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: lane-alignment vector table, randomized accesses
// against a lane-by-lane reference model, and hand-written multi-cycle corner sequences.
module tb_mem_arbiter;

    localparam int TO = 64;

    logic        clk;
    logic        nrst;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        ihit;
    logic [31:0] imem_load;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [2:0]  dmem_width;
    logic [31:0] dmem_store;
    logic        dhit;
    logic [31:0] dmem_load;
    logic        access_fault;
    logic [31:0] ram_addr;
    logic        ram_ren;
    logic        ram_wen;
    logic [3:0]  ram_be;
    logic [31:0] ram_store;
    logic [31:0] ram_load;
    logic        ram_ready;

    int n_checks = 0;
    int n_err    = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
        .clk(clk), .nrst(nrst),
        .imem_ren(imem_ren), .imem_addr(imem_addr), .ihit(ihit), .imem_load(imem_load),
        .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
        .dmem_width(dmem_width), .dmem_store(dmem_store), .dhit(dhit),
        .dmem_load(dmem_load), .access_fault(access_fault),
        .ram_addr(ram_addr), .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_be(ram_be),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        wen;
        logic [2:0]  width;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] rload;
        logic [3:0]  exp_be;
        logic [31:0] exp_store;
        logic [31:0] exp_load;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lane rule: an n-byte access at offset a occupies lanes a..a+n-1 (lanes past 3 are lost).
    function automatic void model(input logic [2:0] width, input logic [31:0] addr,
                                  input logic [31:0] store, input logic [31:0] rload,
                                  output logic [3:0] be, output logic [31:0] st,
                                  output logic [31:0] ld);
        int n;
        int a;
        n  = (width[1:0] == 2'b00) ? 1 : (width[1:0] == 2'b01) ? 2 : 4;
        a  = (n == 4) ? 0 : int'(addr[1:0]);
        be = 4'b0000;
        st = 32'h0;
        ld = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (k >= a && k < a + n) begin
                be[k]       = 1'b1;
                st[8*k +: 8] = store[8*(k-a) +: 8];
            end
        end
        for (int j = 0; j < n; j++) begin
            if (a + j < 4) ld[8*j +: 8] = rload[8*(a+j) +: 8];
        end
    endfunction

    task automatic run_data(input string tag, input logic wen, input logic [2:0] width,
                            input logic [31:0] addr, input logic [31:0] store,
                            input logic [31:0] rload, input int waits,
                            input logic [3:0] exp_be, input logic [31:0] exp_st,
                            input logic [31:0] exp_ld);
        logic early;
        early      = 1'b0;
        dmem_ren   = !wen;
        dmem_wen   = wen;
        dmem_width = width;
        dmem_addr  = addr;
        dmem_store = store;
        ram_ready  = 1'b0;
        ram_load   = 32'h0;
        tick();
        for (int i = 0; i < waits; i++) begin
            ram_ready = 1'b0;
            ram_load  = $urandom;
            #1;
            if (dhit !== 1'b0 || ihit !== 1'b0) early = 1'b1;
            tick();
        end
        ram_ready = 1'b1;
        ram_load  = rload;
        #1;
        check({tag, " early_hit"}, 32'(early), 32'd0);
        check({tag, " dhit"}, 32'(dhit), 32'd1);
        check({tag, " fault"}, 32'(access_fault), 32'd0);
        check({tag, " ram_addr"}, ram_addr, {addr[31:2], 2'b00});
        check({tag, " ram_be"}, 32'(ram_be), 32'(exp_be));
        check({tag, " strobes"}, {30'h0, ram_ren, ram_wen}, {30'h0, !wen, wen});
        if (wen) check({tag, " ram_store"}, ram_store, exp_st);
        else     check({tag, " dmem_load"}, dmem_load, exp_ld);
        tick();
        dmem_ren  = 1'b0;
        dmem_wen  = 1'b0;
        ram_ready = 1'b0;
        #1;
        check({tag, " idle_after"}, {29'h0, dhit, ram_ren, ram_wen}, 32'd0);
        if (!wen) check({tag, " load_held"}, dmem_load, exp_ld);
    endtask

    task automatic run_fetch(input string tag, input logic [31:0] addr,
                             input logic [31:0] rload, input int waits);
        logic early;
        early     = 1'b0;
        imem_ren  = 1'b1;
        imem_addr = addr;
        ram_ready = 1'b0;
        tick();
        for (int i = 0; i < waits; i++) begin
            ram_ready = 1'b0;
            ram_load  = $urandom;
            #1;
            if (ihit !== 1'b0 || dhit !== 1'b0) early = 1'b1;
            tick();
        end
        ram_ready = 1'b1;
        ram_load  = rload;
        #1;
        check({tag, " early_hit"}, 32'(early), 32'd0);
        check({tag, " ihit"}, 32'(ihit), 32'd1);
        check({tag, " imem_load"}, imem_load, rload);
        check({tag, " ram_addr"}, ram_addr, {addr[31:2], 2'b00});
        check({tag, " ram_be"}, 32'(ram_be), 32'hF);
        check({tag, " strobes"}, {30'h0, ram_ren, ram_wen}, 32'd2);
        tick();
        imem_ren  = 1'b0;
        ram_ready = 1'b0;
        #1;
        check({tag, " idle_after"}, {30'h0, ihit, ram_ren}, 32'd0);
        check({tag, " load_held"}, imem_load, rload);
    endtask

    vec_t vecs[10];

    initial begin
        logic [3:0]  m_be;
        logic [31:0] m_st;
        logic [31:0] m_ld;
        logic        early;

        //         wen   width   addr         store         rload         be       store         load
        vecs[0] = '{1'b1, 3'b000, 32'h203, 32'h1234_56AB, 32'h0,         4'b1000, 32'hAB00_0000, 32'h0};
        vecs[1] = '{1'b0, 3'b001, 32'h202, 32'h0,         32'hBEEF_1234, 4'b1100, 32'h0,         32'h0000_BEEF};
        vecs[2] = '{1'b0, 3'b000, 32'h201, 32'h0,         32'hBEEF_1234, 4'b0010, 32'h0,         32'h0000_0012};
        vecs[3] = '{1'b1, 3'b001, 32'h201, 32'hFFFF_CAFE, 32'h0,         4'b0110, 32'h00CA_FE00, 32'h0};
        vecs[4] = '{1'b1, 3'b001, 32'h203, 32'hFFFF_CAFE, 32'h0,         4'b1000, 32'hFE00_0000, 32'h0};
        vecs[5] = '{1'b0, 3'b010, 32'h205, 32'h0,         32'hDEAD_BEEF, 4'b1111, 32'h0,         32'hDEAD_BEEF};
        vecs[6] = '{1'b0, 3'b011, 32'h208, 32'h0,         32'h0123_4567, 4'b1111, 32'h0,         32'h0123_4567};
        vecs[7] = '{1'b0, 3'b100, 32'h200, 32'h0,         32'hBEEF_1234, 4'b0001, 32'h0,         32'h0000_0034};
        vecs[8] = '{1'b1, 3'b010, 32'h20C, 32'h89AB_CDEF, 32'h0,         4'b1111, 32'h89AB_CDEF, 32'h0};
        vecs[9] = '{1'b0, 3'b101, 32'h203, 32'h0,         32'hBEEF_1234, 4'b1000, 32'h0,         32'h0000_00BE};

        nrst       = 1'b0;
        imem_ren   = 1'b0;
        imem_addr  = 32'h0;
        dmem_ren   = 1'b0;
        dmem_wen   = 1'b0;
        dmem_addr  = 32'h0;
        dmem_width = 3'b000;
        dmem_store = 32'h0;
        ram_load   = 32'h0;
        ram_ready  = 1'b0;

        // Reset state
        repeat (2) tick();
        check("reset ram_bus", {ram_addr[27:0], ram_be}, 32'd0);
        check("reset strobes_hits", {27'h0, ram_ren, ram_wen, ihit, dhit, access_fault}, 32'd0);
        check("reset imem_load", imem_load, 32'h0);
        check("reset dmem_load", dmem_load, 32'h0);
        check("reset ram_store", ram_store, 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        tick();

        // Word fetch at minimum latency
        run_fetch("fetch_word", 32'h100, 32'h0050_0093, 0);

        // Lane-alignment vectors
        for (int i = 0; i < 10; i++) begin
            run_data($sformatf("vec%0d", i), vecs[i].wen, vecs[i].width, vecs[i].addr,
                     vecs[i].store, vecs[i].rload, i % 3, vecs[i].exp_be,
                     vecs[i].exp_store, vecs[i].exp_load);
        end

        // Data priority over a simultaneous fetch
        imem_ren   = 1'b1;
        imem_addr  = 32'h100;
        dmem_ren   = 1'b1;
        dmem_width = 3'b010;
        dmem_addr  = 32'h204;
        tick();
        ram_ready = 1'b1;
        ram_load  = 32'h5555_AAAA;
        #1;
        check("prio dhit", {30'h0, dhit, ihit}, 32'd2);
        check("prio ram_addr", ram_addr, 32'h204);
        check("prio dmem_load", dmem_load, 32'h5555_AAAA);
        tick();
        dmem_ren  = 1'b0;
        ram_ready = 1'b0;
        #1;
        check("prio gap_idle", {29'h0, ram_ren, ihit, dhit}, 32'd0);
        tick();
        ram_ready = 1'b1;
        ram_load  = 32'h0000_0013;
        #1;
        check("prio ihit", 32'(ihit), 32'd1);
        check("prio fetch_addr", ram_addr, 32'h100);
        check("prio imem_load", imem_load, 32'h0000_0013);
        tick();
        imem_ren  = 1'b0;
        ram_ready = 1'b0;

        // Fetch abort on address change
        imem_ren  = 1'b1;
        imem_addr = 32'h100;
        tick();
        imem_addr = 32'h200;
        #1;
        check("abort no_ihit", 32'(ihit), 32'd0);
        tick();
        #1;
        check("abort idle", {30'h0, ram_ren, ihit}, 32'd0);
        tick();
        ram_ready = 1'b1;
        ram_load  = 32'h1111_2222;
        #1;
        check("abort refetch_addr", ram_addr, 32'h200);
        check("abort refetch_ihit", {30'h0, ihit, ram_ren}, 32'd3);
        tick();
        imem_ren  = 1'b0;
        ram_ready = 1'b0;

        // Fetch abort on request drop
        imem_ren  = 1'b1;
        imem_addr = 32'h300;
        tick();
        imem_ren  = 1'b0;
        #1;
        check("drop no_ihit", 32'(ihit), 32'd0);
        tick();
        #1;
        check("drop idle", {30'h0, ram_ren, ihit}, 32'd0);

        // Watchdog timeout on a load
        dmem_ren   = 1'b1;
        dmem_width = 3'b010;
        dmem_addr  = 32'h300;
        ram_ready  = 1'b0;
        ram_load   = 32'hFFFF_FFFF;
        early      = 1'b0;
        tick();
        for (int k = 1; k < TO; k++) begin
            #1;
            if (dhit !== 1'b0 || access_fault !== 1'b0) early = 1'b1;
            tick();
        end
        #1;
        check("timeout early", 32'(early), 32'd0);
        check("timeout dhit_fault", {30'h0, dhit, access_fault}, 32'd3);
        check("timeout dmem_load", dmem_load, 32'h0);
        tick();
        dmem_ren = 1'b0;
        #1;
        check("timeout after", {29'h0, dhit, access_fault, ram_ren}, 32'd0);
        check("timeout load_held", dmem_load, 32'h0);
        run_data("post_timeout", 1'b0, 3'b010, 32'h304, 32'h0, 32'hCAFE_F00D, 1,
                 4'hF, 32'h0, 32'hCAFE_F00D);
        // ram_ready arriving on the timeout cycle is a normal completion
        run_data("ready_at_limit", 1'b0, 3'b001, 32'h306, 32'h0, 32'hABCD_0000, TO - 1,
                 4'b1100, 32'h0, 32'h0000_ABCD);

        // Reset mid-store
        dmem_wen   = 1'b1;
        dmem_width = 3'b010;
        dmem_addr  = 32'h210;
        dmem_store = 32'h7777_7777;
        tick();
        #1;
        check("rst_store wen_before", 32'(ram_wen), 32'd1);
        nrst = 1'b0;
        #1;
        check("rst_store dropped", {29'h0, ram_wen, ram_ren, dhit}, 32'd0);
        dmem_wen = 1'b0;
        tick();
        nrst = 1'b1;
        tick();
        #1;
        check("rst_store idle", {29'h0, ram_wen, ram_ren, dhit}, 32'd0);
        run_data("post_reset", 1'b0, 3'b000, 32'h213, 32'h0, 32'h9900_0000, 0,
                 4'b1000, 32'h0, 32'h0000_0099);

        // Randomized accesses against the lane model
        for (int t = 0; t < 40; t++) begin
            logic [31:0] r_addr;
            logic [31:0] r_store;
            logic [31:0] r_load;
            logic [2:0]  r_width;
            int          kind;
            int          waits;
            kind    = $urandom_range(0, 2);
            waits   = $urandom_range(0, 4);
            r_addr  = $urandom;
            r_store = $urandom;
            r_load  = $urandom;
            r_width = 3'($urandom_range(0, 7));
            if (kind == 0) begin
                run_fetch($sformatf("rnd%0d_fetch", t), r_addr, r_load, waits);
            end else begin
                model(r_width, r_addr, r_store, r_load, m_be, m_st, m_ld);
                run_data($sformatf("rnd%0d_data", t), kind == 2, r_width, r_addr, r_store,
                         r_load, waits, m_be, m_st, m_ld);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
